// File: rtl/sft_seq.sv
// sft_seq: command sequencer in front of the 74HC595-style shift block.
// Bytes are queued in a small FIFO. A START pulse then plays out the command
// list [MR], N x shift, storage latch, output enable, waiting for the shift
// block's done pulse after each command. A watchdog aborts the sequence when
// the shift block stops answering.
module sft_seq #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          WR_EN,
  input  logic [7:0]    WR_DAT,
  output logic          FIFO_FULL,
  output logic [AW:0]   FIFO_CNT,
  input  logic          START,
  input  logic          CLR_FIRST,
  input  logic          OEN_CFG,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic          SFT_VLD,
  output logic [1:0]    SFT_CMD,
  output logic          SFT_OEN,
  output logic [7:0]    SFT_DIN,
  input  logic          SFT_DONE
);

  // The wait counter only has to reach TIMEOUT-1, so TIMEOUT values need
  // $clog2(TIMEOUT) bits (at least one).
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   DEPTH_CNT  = (AW + 1)'(DEPTH);

  localparam logic [1:0] CMD_MR    = 2'b00;
  localparam logic [1:0] CMD_SHIFT = 2'b01;
  localparam logic [1:0] CMD_STORE = 2'b10;
  localparam logic [1:0] CMD_OE    = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  state_t         state;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    fifo_cnt;
  logic [AW:0]    shifts_left;
  logic [TW-1:0]  timer;
  logic           oen_cfg_q;
  logic           busy;
  logic           done;
  logic           err;
  logic           sft_vld;
  logic [1:0]     sft_cmd;
  logic           sft_oen;
  logic [7:0]     sft_din;
  logic [7:0]     head;
  logic           push;
  logic           pop;
  logic           flush;
  logic [1:0]     next_cmd;

  assign head  = mem[rd_ptr];
  assign pop   = (state == ISSUE) && (sft_cmd == CMD_SHIFT);
  assign flush = (state == WAIT) && !SFT_DONE && (timer == TIMER_LAST);
  assign push  = WR_EN && (fifo_cnt != DEPTH_CNT) && !flush;
  assign busy  = (state != IDLE);

  assign FIFO_FULL = (fifo_cnt == DEPTH_CNT);
  assign FIFO_CNT  = fifo_cnt;
  assign BUSY      = busy;
  assign DONE      = done;
  assign ERR       = err;
  assign SFT_VLD   = sft_vld;
  assign SFT_CMD   = sft_cmd;
  assign SFT_OEN   = sft_oen;
  assign SFT_DIN   = sft_din;

  // Byte storage; the array is not reset, only the pointers and count are.
  always_ff @(posedge CLK_I) begin
    if (push) begin
      mem[wr_ptr] <= WR_DAT;
    end
  end

  // FIFO pointers and occupancy; a timeout flush wins over any push or pop.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      rd_ptr   <= wr_ptr;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Pick the command to issue next: the first one when leaving IDLE, the
  // follower of the current command when its done pulse arrives.
  always_comb begin
    next_cmd = CMD_STORE;
    if (state == IDLE) begin
      if (CLR_FIRST) begin
        next_cmd = CMD_MR;
      end else if (fifo_cnt != '0) begin
        next_cmd = CMD_SHIFT;
      end else begin
        next_cmd = CMD_STORE;
      end
    end else begin
      case (sft_cmd)
        CMD_MR, CMD_SHIFT: next_cmd = (shifts_left != '0) ? CMD_SHIFT : CMD_STORE;
        CMD_STORE:         next_cmd = CMD_OE;
        default:           next_cmd = CMD_OE;
      endcase
    end
  end

  // Sequencer FSM with registered command outputs, done pulse and error flag.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state       <= IDLE;
      sft_vld     <= 1'b0;
      sft_cmd     <= CMD_MR;
      sft_oen     <= 1'b1;
      sft_din     <= 8'h00;
      done        <= 1'b0;
      err         <= 1'b0;
      shifts_left <= '0;
      oen_cfg_q   <= 1'b1;
      timer       <= '0;
    end else begin
      sft_vld <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            err       <= 1'b0;
            oen_cfg_q <= OEN_CFG;
            state     <= ISSUE;
            sft_vld   <= 1'b1;
            sft_cmd   <= next_cmd;
            sft_oen   <= 1'b1;
            sft_din   <= (next_cmd == CMD_SHIFT) ? head : 8'h00;
            shifts_left <= (next_cmd == CMD_SHIFT) ? fifo_cnt - 1'b1 : fifo_cnt;
          end
        end
        ISSUE: begin
          state <= WAIT;
          timer <= '0;
        end
        WAIT: begin
          if (SFT_DONE) begin
            if (sft_cmd == CMD_OE) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state   <= ISSUE;
              sft_vld <= 1'b1;
              sft_cmd <= next_cmd;
              sft_oen <= (next_cmd == CMD_OE) ? oen_cfg_q : 1'b1;
              sft_din <= (next_cmd == CMD_SHIFT) ? head : 8'h00;
              if (next_cmd == CMD_SHIFT) begin
                shifts_left <= shifts_left - 1'b1;
              end
            end
          end else if (timer == TIMER_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sft_seq.sv
// tb_sft_seq: self-checking bench for sft_seq. A queue-based reference model
// predicts every command the sequencer should issue, its timing, and the FIFO
// occupancy each cycle; a small responder plays the shift block's done pulse.
module tb_sft_seq;

  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic [1:0] cmd;
    logic       oen;
    logic [7:0] din;
  } cmd_t;

  logic          CLK_I = 1'b0;
  logic          RST_I = 1'b0;
  logic          WR_EN = 1'b0;
  logic [7:0]    WR_DAT = 8'h00;
  logic          FIFO_FULL;
  logic [AW:0]   FIFO_CNT;
  logic          START = 1'b0;
  logic          CLR_FIRST = 1'b0;
  logic          OEN_CFG = 1'b1;
  logic          BUSY;
  logic          DONE;
  logic          ERR;
  logic          SFT_VLD;
  logic [1:0]    SFT_CMD;
  logic          SFT_OEN;
  logic [7:0]    SFT_DIN;
  logic          SFT_DONE = 1'b0;

  int compare_count  = 0;
  int mismatch_count = 0;
  int cyc            = 0;

  // Reference model state
  logic [7:0] q[$];
  cmd_t       exp_q[$];
  int         pending    = 0;
  bit         seq_active = 0;
  bit         first_vld  = 0;
  bit         issued     = 0;
  int         start_cyc  = 0;
  int         done_cyc   = -100;
  int         flush_cyc  = -1;
  cmd_t       last_cmd;
  int         cnt_now;
  int         n_snap;
  cmd_t       e;
  logic [7:0] b;

  // Responder mode: 0 answers 4 cycles after VLD, 1 never answers,
  // 2 also pulses done during the issue cycle and answers 6 cycles later.
  int resp_mode = 0;
  int resp_cd   = 0;

  sft_seq #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .WR_EN(WR_EN), .WR_DAT(WR_DAT),
    .FIFO_FULL(FIFO_FULL), .FIFO_CNT(FIFO_CNT), .START(START),
    .CLR_FIRST(CLR_FIRST), .OEN_CFG(OEN_CFG), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .SFT_VLD(SFT_VLD), .SFT_CMD(SFT_CMD), .SFT_OEN(SFT_OEN),
    .SFT_DIN(SFT_DIN), .SFT_DONE(SFT_DONE)
  );

  initial forever #5 CLK_I = ~CLK_I;

  always @(posedge CLK_I) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    compare_count++;
    if (got !== expv) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  // Shift-block stand-in driving SFT_DONE just after each rising edge.
  initial begin
    forever begin
      @(posedge CLK_I);
      #1;
      SFT_DONE = 1'b0;
      if (RST_I) begin
        resp_cd = 0;
      end else begin
        if (resp_cd > 0) begin
          resp_cd--;
          if (resp_cd == 0) begin
            SFT_DONE = 1'b1;
            done_cyc = cyc;
          end
        end
        if (SFT_VLD) begin
          if (resp_mode == 0) begin
            resp_cd = 4;
          end else if (resp_mode == 2) begin
            SFT_DONE = 1'b1;
            resp_cd  = 6;
          end
        end
      end
    end
  end

  // Reference model and monitor, evaluated mid-cycle.
  always @(negedge CLK_I) begin
    if (!RST_I) begin
      if (cyc == flush_cyc) begin
        q.delete();
        exp_q.delete();
        pending    = 0;
        seq_active = 0;
      end
      cnt_now = q.size() + pending;
      checkOutput("fifo_cnt", FIFO_CNT, cnt_now);
      checkOutput("fifo_full", FIFO_FULL, (cnt_now == DEPTH));
      if (SFT_VLD) begin
        if (!seq_active || exp_q.size() == 0) begin
          checkOutput("vld_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("vld_cmd", SFT_CMD, e.cmd);
          checkOutput("vld_oen", SFT_OEN, e.oen);
          if (e.cmd == 2'b01) checkOutput("vld_din", SFT_DIN, e.din);
          checkOutput("vld_latency", cyc, first_vld ? start_cyc + 1 : done_cyc + 1);
          first_vld = 0;
          issued    = 1;
          last_cmd  = e;
          if (e.cmd == 2'b01) pending--;
          if (resp_mode == 1) flush_cyc = cyc + TIMEOUT + 1;
        end
      end else if (seq_active && issued && !DONE) begin
        checkOutput("hold_cmd", SFT_CMD, last_cmd.cmd);
        checkOutput("hold_oen", SFT_OEN, last_cmd.oen);
        if (last_cmd.cmd == 2'b01) checkOutput("hold_din", SFT_DIN, last_cmd.din);
      end
      if (START && !seq_active) begin
        n_snap = q.size();
        if (CLR_FIRST) exp_q.push_back('{2'b00, 1'b1, 8'h00});
        for (int i = 0; i < n_snap; i++) begin
          b = q.pop_front();
          exp_q.push_back('{2'b01, 1'b1, b});
        end
        exp_q.push_back('{2'b10, 1'b1, 8'h00});
        exp_q.push_back('{2'b11, OEN_CFG, 8'h00});
        pending    = n_snap;
        seq_active = 1;
        first_vld  = 1;
        issued     = 0;
        start_cyc  = cyc;
        flush_cyc  = -1;
      end
      if (DONE) begin
        checkOutput("done_expected", (seq_active && exp_q.size() == 0), 1);
        checkOutput("done_latency", cyc, done_cyc + 1);
        seq_active = 0;
      end
      if (WR_EN && cnt_now < DEPTH) q.push_back(WR_DAT);
    end
  end

  task automatic gotoCycle(input int n);
    while (cyc < n) begin
      @(posedge CLK_I);
      #1;
    end
  endtask

  task automatic pushByte(input logic [7:0] d);
    @(posedge CLK_I);
    #1;
    WR_EN  = 1'b1;
    WR_DAT = d;
    @(posedge CLK_I);
    #1;
    WR_EN  = 1'b0;
  endtask

  task automatic applyStimulus(input int n_bytes, input bit clr, input bit oen);
    for (int i = 0; i < n_bytes; i++) pushByte(8'($urandom));
    @(posedge CLK_I);
    #1;
    START     = 1'b1;
    CLR_FIRST = clr;
    OEN_CFG   = oen;
    @(posedge CLK_I);
    #1;
    START     = 1'b0;
  endtask

  task automatic waitIdle(input bit rand_push);
    int n;
    n = 0;
    while (seq_active && n < 400) begin
      @(posedge CLK_I);
      #1;
      if (rand_push) begin
        WR_EN  = ($urandom_range(0, 3) == 0);
        WR_DAT = 8'($urandom);
      end
      n++;
    end
    WR_EN = 1'b0;
    if (seq_active) begin
      checkOutput("seq_complete", 0, 1);
      seq_active = 0;
      exp_q.delete();
    end
    repeat (2) @(posedge CLK_I);
    #1;
  endtask

  task automatic clearModel();
    q.delete();
    exp_q.delete();
    pending    = 0;
    seq_active = 0;
    flush_cyc  = -1;
  endtask

  task automatic pulseReset();
    @(posedge CLK_I);
    #1;
    RST_I = 1'b1;
    clearModel();
    repeat (2) @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
  endtask

  initial begin
    int s;
    // Asynchronous reset before any clock edge
    #2 RST_I = 1'b1;
    #1;
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_done", DONE, 0);
    checkOutput("rst_err", ERR, 0);
    checkOutput("rst_vld", SFT_VLD, 0);
    checkOutput("rst_cmd", SFT_CMD, 0);
    checkOutput("rst_oen", SFT_OEN, 1);
    checkOutput("rst_din", SFT_DIN, 0);
    checkOutput("rst_cnt", FIFO_CNT, 0);
    checkOutput("rst_full", FIFO_FULL, 0);
    repeat (2) @(posedge CLK_I);
    #1;
    RST_I = 1'b0;

    // Directed: MR, three shifts, storage, OE with OEN=0
    pushByte(8'hA5);
    pushByte(8'h3C);
    pushByte(8'hF0);
    applyStimulus(0, 1'b1, 1'b0);
    waitIdle(1'b0);
    checkOutput("dir_cnt", FIFO_CNT, 0);
    checkOutput("dir_err", ERR, 0);
    checkOutput("dir_busy", BUSY, 0);

    // Randomized sequences, with pushes arriving while busy
    for (int it = 0; it < 8; it++) begin
      applyStimulus($urandom_range(0, DEPTH - q.size()), 1'($urandom), 1'($urandom));
      waitIdle(1'b1);
    end

    // Overfill, then push during the pop cycle of the second shift
    pulseReset();
    for (int i = 0; i < 9; i++) pushByte(8'(8'h10 + i));
    checkOutput("full_flag", FIFO_FULL, 1);
    checkOutput("full_cnt", FIFO_CNT, 8);
    applyStimulus(0, 1'b0, 1'b1);
    s = start_cyc;
    gotoCycle(s + 6);
    checkOutput("pop2_vld", SFT_VLD, 1);
    checkOutput("pop2_cmd", SFT_CMD, 1);
    checkOutput("pop2_cnt_before", FIFO_CNT, 7);
    WR_EN  = 1'b1;
    WR_DAT = 8'h77;
    @(posedge CLK_I);
    #1;
    WR_EN  = 1'b0;
    checkOutput("pop2_cnt_after", FIFO_CNT, 7);
    waitIdle(1'b0);
    checkOutput("late_cnt", FIFO_CNT, 1);
    applyStimulus(0, 1'b0, 1'b1);
    waitIdle(1'b0);
    checkOutput("late_drained", FIFO_CNT, 0);

    // Timeout: the shift block never answers
    resp_mode = 1;
    applyStimulus(2, 1'b0, 1'b1);
    s = start_cyc;
    gotoCycle(s + 16);
    checkOutput("to_err_before", ERR, 0);
    checkOutput("to_busy_before", BUSY, 1);
    gotoCycle(s + 17);
    checkOutput("to_err", ERR, 1);
    checkOutput("to_busy", BUSY, 0);
    checkOutput("to_cnt", FIFO_CNT, 0);
    checkOutput("to_done", DONE, 0);
    waitIdle(1'b0);
    resp_mode = 0;
    applyStimulus(0, 1'b0, 1'b0);
    s = start_cyc;
    gotoCycle(s + 1);
    checkOutput("to_err_cleared", ERR, 0);
    checkOutput("to_busy_again", BUSY, 1);
    waitIdle(1'b0);

    // START while busy is ignored
    applyStimulus(3, 1'b1, 1'b1);
    s = start_cyc;
    gotoCycle(s + 3);
    START = 1'b1;
    @(posedge CLK_I);
    #1;
    START = 1'b0;
    waitIdle(1'b0);
    checkOutput("busy_start_cnt", FIFO_CNT, 0);

    // Done pulse during the issue cycle is ignored
    resp_mode = 2;
    applyStimulus(2, 1'b1, 1'b0);
    waitIdle(1'b0);
    resp_mode = 0;

    // Reset in the middle of WAIT, then an empty-FIFO sequence
    applyStimulus(3, 1'b0, 1'b1);
    s = start_cyc;
    gotoCycle(s + 3);
    RST_I = 1'b1;
    #1;
    clearModel();
    checkOutput("mid_rst_busy", BUSY, 0);
    checkOutput("mid_rst_vld", SFT_VLD, 0);
    checkOutput("mid_rst_cmd", SFT_CMD, 0);
    checkOutput("mid_rst_oen", SFT_OEN, 1);
    checkOutput("mid_rst_din", SFT_DIN, 0);
    checkOutput("mid_rst_cnt", FIFO_CNT, 0);
    checkOutput("mid_rst_done", DONE, 0);
    checkOutput("mid_rst_err", ERR, 0);
    repeat (2) @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    applyStimulus(0, 1'b0, 1'b1);
    waitIdle(1'b0);
    checkOutput("final_busy", BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
